// File: rtl/hazard_scoreboard.sv
// Operand hazard scoreboard: tracks in-flight GPR writes past ID and a mul/div
// busy counter, producing per-source bypass selects and the ID stall.
module hazard_scoreboard #(
  parameter int AW    = 5,
  parameter int NSRC  = 2,
  parameter int DEPTH = 3,
  parameter int SW    = $clog2(DEPTH + 1),
  parameter int MDW   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_hold,
  input  logic               i_flush,
  input  logic               i_id_valid,
  input  logic               i_id_wen,
  input  logic [AW-1:0]      i_id_dst,
  input  logic [SW-1:0]      i_id_rdy,
  input  logic [NSRC-1:0]    i_src_used,
  input  logic [NSRC*AW-1:0] i_src_num,
  input  logic               i_id_hilo_used,
  input  logic               i_id_md_start,
  input  logic [MDW-1:0]     i_id_md_cycles,
  output logic [NSRC*SW-1:0] o_fwd_sel,
  output logic               o_stall,
  output logic               o_load_use,
  output logic               o_md_busy,
  output logic               o_md_done
);

  logic          r_v   [DEPTH];
  logic [AW-1:0] r_dst [DEPTH];
  logic [SW-1:0] r_rdy [DEPTH];

  logic [MDW-1:0] r_mdCount;
  logic           r_mdDone;

  logic w_hazAny;
  logic w_loadUse;
  logic w_mdBusy;
  logic w_mdStall;
  logic w_stall;
  logic w_mdLoad;

  // Youngest matching stage wins, so the search keeps overwriting down to k=0.
  always_comb begin
    logic [AW-1:0] w_srcNum;
    logic          w_hit;
    int            w_hitK;
    w_hazAny  = 1'b0;
    o_fwd_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_srcNum = i_src_num[i*AW +: AW];
      w_hit    = 1'b0;
      w_hitK   = 0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (r_v[k] && (r_dst[k] == w_srcNum)) begin
          w_hit  = 1'b1;
          w_hitK = k;
        end
      end
      if (i_src_used[i] && (w_srcNum != '0) && w_hit) begin
        if (w_hitK >= int'(r_rdy[w_hitK])) begin
          o_fwd_sel[i*SW +: SW] = SW'(w_hitK + 1);
        end else begin
          w_hazAny = 1'b1;
        end
      end
    end
  end

  assign w_mdBusy   = (r_mdCount != '0);
  assign w_loadUse  = i_id_valid & w_hazAny;
  assign w_mdStall  = i_id_valid & w_mdBusy & (i_id_hilo_used | i_id_md_start);
  assign w_stall    = w_loadUse | w_mdStall;
  assign w_mdLoad   = i_id_valid & i_id_md_start & ~w_stall & ~i_flush;

  assign o_stall    = w_stall;
  assign o_load_use = w_loadUse;
  assign o_md_busy  = w_mdBusy;
  assign o_md_done  = r_mdDone;

  // A flush kills both the ID instruction and the stage-0 entry moving to stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_v[k]   <= 1'b0;
        r_dst[k] <= '0;
        r_rdy[k] <= '0;
      end
    end else if (!i_hold) begin
      r_v[0]   <= i_id_valid & i_id_wen & (i_id_dst != '0) & ~w_stall & ~i_flush;
      r_dst[0] <= i_id_dst;
      r_rdy[0] <= i_id_rdy;
      for (int k = 1; k < DEPTH; k++) begin
        r_v[k]   <= (k == 1 && i_flush) ? 1'b0 : r_v[k-1];
        r_dst[k] <= r_dst[k-1];
        r_rdy[k] <= r_rdy[k-1];
      end
    end
  end

  // A running mul/div is not aborted by flush; only hold and reset affect it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mdCount <= '0;
      r_mdDone  <= 1'b0;
    end else if (!i_hold) begin
      r_mdDone <= (r_mdCount == MDW'(1)) && !w_mdLoad;
      if (w_mdLoad) begin
        r_mdCount <= i_id_md_cycles;
      end else if (r_mdCount != '0) begin
        r_mdCount <= r_mdCount - MDW'(1);
      end
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the combinational data-conflict controller. It holds a registered shadow of the in-flight destination writes for DEPTH pipeline stages past ID. For each of NSRC source operands it issues a forward-select or a stall, honouring per-instruction result latency. It also tracks a multi-cycle HI/LO (mul/div) unit with a busy counter. It sits beside the ID stage and drives the operand bypass muxes and the ID/EX stall/bubble control.

## Interface
Parameters:
- AW, 5: register-number width (2^AW GPRs; register 0 is hardwired zero).
- NSRC, 2: number of source operands checked per ID instruction.
- DEPTH, 3: tracked stages after ID; index 0=EX, 1=MEM, 2=WB, …
- SW, $clog2(DEPTH+1): forward-select code width.
- MDW, 6: mul/div cycle-counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- hold  in  1  external whole-pipeline freeze (e.g. memory wait).
- flush  in  1  kill the instruction in ID and the entry in stage 0.
- id_valid  in  1  ID holds a real instruction.
- id_wen  in  1  ID instruction writes a GPR.
- id_dst  in  AW  ID destination register.
- id_rdy  in  SW  first stage index at which its result is forwardable (0=ALU at EX, 1=load at MEM).
- src_used  in  NSRC  per-source "operand read" flags.
- src_num  in  NSRC*AW  packed source register numbers; source i is at [i*AW +: AW].
- id_hilo_used  in  1  ID reads HI/LO (mfhi/mflo).
- id_md_start  in  1  ID is a mul/div.
- id_md_cycles  in  MDW  its latency in cycles (≥1).
- fwd_sel  out  NSRC*SW  per source: 0 = register file; k+1 = bypass from stage k.
- stall  out  1  hold PC and ID, inject a bubble into EX.
- load_use  out  1  stall caused by a GPR hazard.
- md_busy  out  1  mul/div in progress.
- md_done  out  1  one-cycle pulse when the mul/div finishes.

## Operation
- Entry per stage k: {v, dst, rdy}. stage[k] is valid only if its instruction writes a GPR, dst != 0, and it is not killed.
- Source i hazard search:
  - Only when src_used[i]=1 and src_num[i] != 0.
  - Find the smallest k with stage[k].v and stage[k].dst == src_num[i]. The youngest write wins.
  - No match: fwd_sel_i = 0.
  - Match with k ≥ stage[k].rdy: fwd_sel_i = k+1.
  - Match with k < rdy: GPR hazard; fwd_sel_i = 0 (don't care).
- load_use = id_valid & any GPR hazard.
- md stall = id_valid & md_busy & (id_hilo_used | id_md_start).
- stall = load_use | md stall.
- Shift on each clock edge where hold=0:
  - stage[k] <= stage[k-1] for k ≥ 1.
  - stage[0] <= {id_valid & id_wen & (id_dst != 0) & !stall & !flush, id_dst, id_rdy}.
- flush with hold=0: the stage[0] entry is dropped (not shifted into stage 1); stage 1 receives an invalid entry. Other stages shift normally.
- hold=1: all state frozen. Outputs are still recomputed combinationally. flush is ignored.
- Mul/div counter:
  - Loads id_md_cycles when id_valid & id_md_start & !stall & !flush & !hold.
  - Otherwise decrements while non-zero and hold=0.
  - md_busy = (count != 0).
  - md_done is registered: set for one cycle on the edge where count goes 1→0.
  - flush does not abort a mul/div already counting.
- Entries leaving stage DEPTH-1 are discarded. The register file is then assumed to hold the value (write-first regfile).

## Timing
- Reset (rst_n=0, asynchronous): all stage v=0, count=0, md_done=0. Consequently stall=0, load_use=0, md_busy=0, fwd_sel=0.
- fwd_sel, stall and load_use are combinational from registered state plus the current ID inputs. Zero added latency; they are valid in the same cycle.
- Load-use (rdy=1) against an immediate consumer: exactly 1 stall cycle, then fwd_sel=2 (MEM).
- ALU producer (rdy=0): never stalls. fwd_sel=1, then 2, then 3 in successive cycles if the consumer is in ID in each of them.
- Mul/div with N cycles: md_busy is high for N cycles, starting the cycle after issue. md_done pulses in the cycle after the last busy cycle. A dependent mfhi in ID stalls until md_busy=0.
- Asynchronous reset mid-operation clears everything immediately. No pending hazard survives.

## Test plan
- ALU then dependent: add r3 issued, next ID reads r3 on src 0 → stall=0, fwd_sel[0]=1. Hold ID one more cycle → fwd_sel[0]=2.
- Load-use: lw r5 (rdy=1), next ID reads r5 on src 1 → stall=1, load_use=1 for 1 cycle; next cycle stall=0, fwd_sel[1]=2.
- Youngest wins: r7 written at stage 2 and stage 0 (rdy=0), src 0 = r7 → fwd_sel[0]=1. Any src = r0 → fwd_sel=0 and no stall.
- Mul/div: id_md_cycles=4 issued → md_busy for 4 cycles. mfhi in ID stalls those 4 cycles. md_done=1 on the 5th cycle, where stall=0.
- Flush and hold:
  - lw r9 in stage 0 with flush=1 → the next-cycle reader of r9 sees fwd_sel=0, stall=0.
  - hold=1 for 3 cycles → stage contents and count unchanged.
- Reset: assert rst_n=0 mid mul/div and while an entry is pending → md_busy=0, stall=0, fwd_sel=0 immediately, without waiting for a clock edge.
